// File: rtl/dfs_req_sched.sv
// DFS request scheduler: round-robin arbitration of frequency-change requests,
// one clock-mux command per grant, then a fixed settle wait before ack.
// Optional DFS_SKIP_SAME_LVL_EN: grants at the already-applied level ack without issuing.
module dfs_req_sched #(
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [7:0] req_lvl,
  output logic [3:0] ack,
  output logic [5:0] op_code,
  output logic       op_vld,
  output logic [1:0] cur_lvl,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  last_gnt;
  logic [1:0]  cand;
  logic [1:0]  arb_idx;
  logic        arb_hit;
  logic [1:0]  lvl_sel;
  logic        skip_d;
  logic        skip_q;
  logic [7:0]  cnt;
  logic        done;

  // Search starts one past the last grant; the 2-bit add provides the 3->0 wrap.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = last_gnt;
    cand    = last_gnt;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_gnt + 2'(k);
      if (!arb_hit && req[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  always_comb begin
    lvl_sel = req_lvl[{arb_idx, 1'b0} +: 2];
`ifdef DFS_SKIP_SAME_LVL_EN
    skip_d  = (lvl_sel == cur_lvl);
`else
    skip_d  = 1'b0;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_hit) state_nxt = ISSUE;
      ISSUE:   state_nxt = skip_q ? IDLE : SETTLE;
      SETTLE:  if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A skipped grant still passes through ISSUE so the ack cycle blocks re-arbitration.
  always_comb begin
    done   = ((state == ISSUE) && skip_q) || ((state == SETTLE) && (cnt == '0));
    op_vld = (state == ISSUE) && !skip_q;
    busy   = (state != IDLE);
    ack    = done ? (4'b0001 << last_gnt) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 2'd3;
      skip_q   <= 1'b0;
      cnt      <= '0;
      op_code  <= '0;
      cur_lvl  <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && arb_hit) begin
        last_gnt <= arb_idx;
        skip_q   <= skip_d;
        if (!skip_d) begin
          op_code <= {4'b0000, lvl_sel};
          cur_lvl <= lvl_sel;
        end
      end
      if ((state == ISSUE) && !skip_q) begin
        cnt <= 8'(SETTLE_CYC - 1);
      end else if ((state == SETTLE) && (cnt != '0)) begin
        cnt <= cnt - 8'd1;
      end
    end
  end

endmodule

// File: doc/dfs_req_sched.md
DFS_REQ_SCHED -- requirements
Module: dfs_req_sched

Interface
REQ-001 The module SHALL have parameter SETTLE_CYC, default 16, meaning the clock-switch settle time in clk cycles; legal range 1..255.
REQ-002 The module SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-003 The module SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 The module SHALL have port req  input  4  per-requester frequency-change request, held high until ack.
REQ-005 The module SHALL have port req_lvl  input  8  requested level, 2 bits per requester; requester i uses bits [2i+1:2i].
REQ-006 The module SHALL have port ack  output  4  one-cycle completion pulse, one-hot, to the granted requester.
REQ-007 The module SHALL have port op_code  output  6  registered command to the clock-mux core; [1:0] = level (clock source index), [5:2] = 0.
REQ-008 The module SHALL have port op_vld  output  1  one-cycle strobe marking a new op_code.
REQ-009 The module SHALL have port cur_lvl  output  2  currently applied level.
REQ-010 The module SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, ISSUE and SETTLE.
REQ-012 In IDLE, when any req bit is high at a rising edge, the block SHALL grant one requester by round-robin and enter ISSUE on that edge.
REQ-013 Round-robin priority SHALL start at (last granted index + 1) mod 4 and wrap 3->0; the pointer SHALL advance only on a grant.
REQ-014 The level latched at grant SHALL be req_lvl of the granted requester; later req_lvl changes SHALL NOT affect the in-flight operation.
REQ-015 In ISSUE, which lasts one cycle, the block SHALL drive op_code = {4'b0000, latched level} and op_vld = 1, update cur_lvl, load the settle counter with SETTLE_CYC-1 and enter SETTLE.
REQ-016 In SETTLE, the counter SHALL decrement each cycle; at zero, the block SHALL pulse ack for the granted requester for one cycle and return to IDLE.
REQ-017 The latency from the grant edge N SHALL be: op_vld at cycle N+1 and ack at cycle N+1+SETTLE_CYC.
REQ-018 Requests arriving or dropping during ISSUE or SETTLE SHALL be ignored until IDLE; a granted request SHALL NOT be cancelled.
REQ-019 The first arbitration after ack SHALL occur at the edge following the return to IDLE, so there is no back-to-back grant in the ack cycle.
REQ-020 op_code and cur_lvl SHALL hold their values between operations.
REQ-021 At most one ack bit SHALL be high in any cycle.

Reset
REQ-022 rst high SHALL immediately force state IDLE, op_code=0, op_vld=0, ack=0, cur_lvl=0, busy=0, counter=0 and the RR pointer so that requester 0 has the highest priority.
REQ-023 A reset asserted mid-SETTLE SHALL abort the operation with no ack; after release, a still-high req SHALL be re-arbitrated normally.

Configuration
REQ-024 The macro DFS_SKIP_SAME_LVL_EN SHALL control same-level skipping.
REQ-025 When DFS_SKIP_SAME_LVL_EN is defined, a grant whose level equals cur_lvl SHALL produce no op_vld and no settle; ack SHALL pulse at N+1, the FSM SHALL return to IDLE and the RR pointer SHALL still advance.
REQ-026 When DFS_SKIP_SAME_LVL_EN is not defined, every grant SHALL perform the full ISSUE/SETTLE sequence.

Verification
REQ-027 Single request: after reset, req=0001 and lvl0=2 -> op_code=6'b000010 with op_vld at N+1, ack=0001 at N+17, cur_lvl=2.
REQ-028 Contention: req=1111 held, each requester dropping its req after its ack -> grants in order 0,1,2,3; each ack is 17 cycles after its grant edge; no overlap.
REQ-029 Wrap-around: last grant=3, then req=1001 -> requester 0 is granted next, then requester 3.
REQ-030 Mid-op change: lvl1 changes 1->3 during SETTLE -> op_code keeps 1; ack is unaffected.
REQ-031 Reset in SETTLE: rst pulsed at N+5 -> no ack; outputs reach their reset values; req still high -> a new grant follows release.
REQ-032 Skip (macro on, cur_lvl=2, request lvl=2) -> no op_vld, ack at N+1; with the macro off -> the full 17-cycle sequence.
